// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: operand widths and the
// modular-exponentiation controller state encoding.
package rsa_pkg;

  localparam int unsigned WIDTH = 256;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIT,
    S_MUL_REQ,
    S_MUL_WAIT,
    S_SQR_REQ,
    S_SQR_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/mod_exp_ctrl.sv
// Right-to-left square-and-multiply controller for base^exp mod n, driving an
// external modular-product unit through the o_mul_*/i_mul_* handshake.
module mod_exp_ctrl
  import rsa_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_base,
  input  logic [WIDTH-1:0] i_exp,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_result,
  output logic             o_finish,
  output logic             o_busy,
  output logic             o_mul_start,
  output logic [WIDTH-1:0] o_mul_a,
  output logic [WIDTH-1:0] o_mul_b,
  output logic [WIDTH-1:0] o_mul_n,
  input  logic [WIDTH-1:0] i_mul_result,
  input  logic             i_mul_finish
);

  state_t             state;
  logic [WIDTH-1:0]   base_r;
  logic [WIDTH-1:0]   exp_r;
  logic [WIDTH-1:0]   n_r;
  logic [WIDTH-1:0]   res_r;
  logic [CNT_W-1:0]   cnt;

  assign o_result = res_r;

  // The request pulse and operands are registered on entry to a REQ state,
  // so o_mul_start is high exactly during the REQ cycle and the operands
  // stay frozen through the following WAIT state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      base_r      <= '0;
      exp_r       <= '0;
      n_r         <= '0;
      res_r       <= '0;
      cnt         <= '0;
      o_finish    <= 1'b0;
      o_busy      <= 1'b0;
      o_mul_start <= 1'b0;
      o_mul_a     <= '0;
      o_mul_b     <= '0;
      o_mul_n     <= '0;
    end else begin
      o_finish    <= 1'b0;
      o_mul_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            base_r <= i_base;
            exp_r  <= i_exp;
            n_r    <= i_n;
            cnt    <= '0;
            o_busy <= 1'b1;
            if (i_n > WIDTH'(1)) begin
              res_r <= WIDTH'(1);
              state <= S_BIT;
            end else begin
              res_r    <= '0;
              o_finish <= 1'b1;
              state    <= S_DONE;
            end
          end
        end

        S_BIT: begin
          if (exp_r[cnt]) begin
            o_mul_start <= 1'b1;
            o_mul_a     <= res_r;
            o_mul_b     <= base_r;
            o_mul_n     <= n_r;
            state       <= S_MUL_REQ;
          end else if (cnt == '1) begin
            o_finish <= 1'b1;
            state    <= S_DONE;
          end else begin
            o_mul_start <= 1'b1;
            o_mul_a     <= base_r;
            o_mul_b     <= base_r;
            o_mul_n     <= n_r;
            state       <= S_SQR_REQ;
          end
        end

        S_MUL_REQ: state <= S_MUL_WAIT;

        S_MUL_WAIT: begin
          if (i_mul_finish) begin
            res_r <= i_mul_result;
            // The squaring after the last bit would be wasted work.
            if (cnt == '1) begin
              o_finish <= 1'b1;
              state    <= S_DONE;
            end else begin
              o_mul_start <= 1'b1;
              o_mul_a     <= base_r;
              o_mul_b     <= base_r;
              o_mul_n     <= n_r;
              state       <= S_SQR_REQ;
            end
          end
        end

        S_SQR_REQ: state <= S_SQR_WAIT;

        S_SQR_WAIT: begin
          if (i_mul_finish) begin
            base_r <= i_mul_result;
            cnt    <= cnt + 1'b1;
            state  <= S_BIT;
          end
        end

        S_DONE: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Scoreboard bench for mod_exp_ctrl with a behavioural modular-product
// responder of configurable latency.
module tb_mod_exp_ctrl;
  import rsa_pkg::*;

  typedef struct {
    logic [WIDTH-1:0] res;
    int unsigned      lat;
    int unsigned      nreq;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] base, expo, modn;
  logic [WIDTH-1:0] result;
  logic             finish, busy;
  logic             mul_start;
  logic [WIDTH-1:0] mul_a, mul_b, mul_n;
  logic [WIDTH-1:0] mul_result;
  logic             mul_finish;

  int unsigned errs = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  int unsigned lat = 3;
  int unsigned rem = 0;
  int unsigned unstable = 0;
  int unsigned stray_seen = 0;
  int unsigned starts = 0;
  int unsigned gaps = 0;
  int unsigned acc_cyc = 0;
  int unsigned done_cnt = 0;
  bit          in_run = 0;
  logic [WIDTH-1:0] cap_a, cap_b, cap_n;
  exp_t sbq[$];

  mod_exp_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_base      (base),
    .i_exp       (expo),
    .i_n         (modn),
    .o_result    (result),
    .o_finish    (finish),
    .o_busy      (busy),
    .o_mul_start (mul_start),
    .o_mul_a     (mul_a),
    .o_mul_b     (mul_b),
    .o_mul_n     (mul_n),
    .i_mul_result(mul_result),
    .i_mul_finish(mul_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
    end
  endtask

  function automatic logic [WIDTH-1:0] mulmod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] n);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    p = p % {{WIDTH{1'b0}}, n};
    return p[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] e,
                                              input logic [WIDTH-1:0] n);
    logic [WIDTH-1:0] r, x;
    r = (n == 1) ? '0 : WIDTH'(1);
    x = b;
    for (int i = 0; i < WIDTH; i++) begin
      if (e[i]) r = mulmod(r, x, n);
      x = mulmod(x, x, n);
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rand256();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Product responder: answers L cycles after the request cycle.
  always @(negedge clk) begin
    mul_finish = 1'b0;
    if (rem > 0) begin
      if (mul_a !== cap_a || mul_b !== cap_b || mul_n !== cap_n) unstable++;
      rem--;
      if (rem == 0) begin
        mul_finish = 1'b1;
        mul_result = mulmod(cap_a, cap_b, cap_n);
        if (rst == 1'b0 && busy == 1'b0) stray_seen++;
      end
    end
    if (mul_start) begin
      cap_a = mul_a;
      cap_b = mul_b;
      cap_n = mul_n;
      rem   = lat;
    end
  end

  // Monitor: counts requests during a run and scores each completion.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && in_run) begin
      if (mul_start) starts++;
      if (cyc > acc_cyc && !busy) gaps++;
      if (finish) begin
        if (sbq.size() == 0) chk("sb_empty", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("result", result, e.res);
          chk("latency", cyc - acc_cyc, e.lat);
          chk("nreq", starts, e.nreq);
          chk("busy_gap", gaps, 0);
        end
        in_run = 0;
        done_cnt++;
      end
    end
  end

  task automatic launch(input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] n);
    exp_t x;
    @(negedge clk);
    base = b; expo = e; modn = n; start = 1'b1;
    unstable = 0; starts = 0; gaps = 0;
    acc_cyc = cyc;
    in_run = 1;
    x.res  = golden(b, e, n);
    x.nreq = (n == 1) ? 0 : $countones(e) + 255;
    x.lat  = (n == 1) ? 1 : 1 + 256 + x.nreq * (lat + 1);
    sbq.push_back(x);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned d0;
    bit got;
    d0 = done_cnt;
    got = 0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      if (done_cnt != d0) got = 1;
    end
    chk("done_timeout", got, 1);
    chk("stable", unstable, 0);
  endtask

  task automatic run(input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] n);
    launch(b, e, n);
    wait_done();
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_finish"}, finish, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mstart"}, mul_start, 0);
    chk({tag, "_ma"}, mul_a, 0);
    chk({tag, "_mb"}, mul_b, 0);
    chk({tag, "_mn"}, mul_n, 0);
    chk({tag, "_state"}, dut.state, S_IDLE);
  endtask

  initial begin
    logic [WIDTH-1:0] n, b;
    bit hit;
    rst = 1'b1; start = 1'b0; base = '0; expo = '0; modn = '0;
    mul_result = '0; mul_finish = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle_zero("reset");

    lat = 3;
    run(4, 13, 497);
    chk("r4_13_497", result, 445);
    run(7, 0, 497);
    chk("r7_0_497", result, 1);
    run(0, rand256(), 1);
    chk("n1_result", result, 0);

    // Start pulsed mid-run must be ignored.
    launch(4, 13, 497);
    repeat (100) @(negedge clk);
    base = 9; expo = 77; modn = 1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    chk("held_result", result, 445);

    // Reset during a squaring wait, then the late product answer arrives.
    lat = 5;
    launch(4, 13, 497);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (dut.state == S_SQR_WAIT && rem >= 3) hit = 1;
    end
    chk("reach_sqr_wait", hit, 1);
    rst = 1'b1;
    in_run = 0;
    sbq.delete();
    stray_seen = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("stray_seen", stray_seen, 1);
    chk_idle_zero("midrst");
    lat = 3;
    run(4, 13, 497);
    chk("after_rst", result, 445);

    for (int l = 1; l <= 5; l++) begin
      lat = l;
      n = rand256() | 1;
      n[WIDTH-1] = 1'b1;
      b = rand256() % n;
      run(b, '1, n);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mod_exp_ctrl.md
MOD_EXP_CTRL -- requirements
Module: mod_exp_ctrl

Interface
REQ-001 The block SHALL use reset i_rst, asynchronous, active-high, and clock i_clk.
REQ-002 Ports SHALL be:
  i_clk  in  1  clock
  i_rst  in  1  async active-high reset
  i_start  in  1  one-cycle request to compute base^exp mod n
  i_base  in  256  base, caller guarantees i_base < i_n
  i_exp  in  256  exponent
  i_n  in  256  modulus, caller guarantees i_n >= 1
  o_result  out  256  base^exp mod n
  o_finish  out  1  one-cycle done pulse
  o_busy  out  1  high from the cycle after accept until the cycle o_finish is high
  o_mul_start  out  1  one-cycle request to the external modular-product unit
  o_mul_a, o_mul_b, o_mul_n  out  256 each  product operands
  i_mul_result  in  256  (a*b) mod n from the product unit
  i_mul_finish  in  1  one-cycle completion pulse from the product unit

Function
REQ-003 The block SHALL compute base^exp mod n by right-to-left square-and-multiply, processing exp bits 0..255 in order with no early termination.
REQ-004 States SHALL be S_IDLE, S_BIT, S_MUL_REQ, S_MUL_WAIT, S_SQR_REQ, S_SQR_WAIT and S_DONE.
REQ-005 In S_IDLE, i_start SHALL latch i_base, i_exp and i_n, clear the 8-bit bit counter, and go to S_BIT.
REQ-006 On that same accept, res_r SHALL be set to 1 if i_n > 1, and to 0 if i_n == 1.
REQ-007 If i_n == 1, the accept SHALL go directly to S_DONE with no product requests.
REQ-008 In S_BIT:
  - exp_r[cnt]==1 SHALL go to S_MUL_REQ;
  - else cnt==255 SHALL go to S_DONE;
  - else SHALL go to S_SQR_REQ.
REQ-009 S_MUL_REQ SHALL assert o_mul_start for exactly one cycle with a=res_r, b=base_r, n=n_r, then go to S_MUL_WAIT.
REQ-010 S_SQR_REQ SHALL assert o_mul_start for exactly one cycle with a=base_r, b=base_r, n=n_r, then go to S_SQR_WAIT.
REQ-011 o_mul_a, o_mul_b and o_mul_n SHALL be registered and held stable from the REQ cycle until the cycle i_mul_finish is sampled.
REQ-012 In S_MUL_WAIT, i_mul_finish SHALL load res_r from i_mul_result, then go to S_DONE if cnt==255, else to S_SQR_REQ.
REQ-013 In S_SQR_WAIT, i_mul_finish SHALL load base_r from i_mul_result, increment cnt, and go to S_BIT.
REQ-014 The final squaring after bit 255 SHALL NOT be issued.
REQ-015 i_mul_finish outside the WAIT states SHALL be ignored.
REQ-016 S_DONE SHALL drive o_finish high for exactly one cycle, then return to S_IDLE.
REQ-017 o_result SHALL equal res_r, valid from the o_finish cycle and held until the next accepted i_start.
REQ-018 i_start SHALL be ignored in every state except S_IDLE.
REQ-019 Each product op SHALL cost L+1 cycles, where L is the number of cycles from the o_mul_start cycle to the i_mul_finish cycle.
REQ-020 Total latency from the accept cycle to the o_finish cycle SHALL be 1 + 256 + (popcount(exp)+255)*(L+1) cycles when i_n > 1, and 1 cycle when i_n == 1.
REQ-021 All widths SHALL be 256 bits; cnt SHALL be 8 bits and SHALL NOT wrap, because S_DONE is taken at cnt==255.

Reset
REQ-022 i_rst SHALL force S_IDLE, with o_finish=0, o_busy=0, o_mul_start=0, o_result=0, all operand registers 0 and cnt=0.
REQ-023 Reset mid-operation SHALL abandon the computation immediately; a late i_mul_finish after reset SHALL be ignored.

Structure
REQ-024 Shared package rsa_pkg SHALL hold WIDTH=256, CNT_W=8 and the state enum type.
REQ-025 The block SHALL contain no sub-module; the product unit is external and connected via the o_mul_*/i_mul_* ports.
REQ-026 The bench SHALL provide a behavioural product responder with configurable latency L.

Verification
REQ-027 base=4, exp=13, n=497, L=3 -> o_result=445; exactly 258 o_mul_start pulses.
REQ-028 base=7, exp=0, n=497, L=3 -> o_result=1; o_finish 1277 cycles after accept; 255 o_mul_start pulses.
REQ-029 n=1, any base/exp -> o_result=0; o_finish 1 cycle after accept; zero o_mul_start pulses.
REQ-030 i_start pulsed with new operands 100 cycles into a run -> ignored; first run's result unchanged; o_busy stays high throughout.
REQ-031 i_rst asserted during S_SQR_WAIT, then a stray i_mul_finish -> all outputs 0, state S_IDLE; a following run with base=4, exp=13, n=497 returns 445.
REQ-032 exp=all ones, random base<n, random odd n, L varied 1..5 -> 511 requests; o_result matches the golden model; operands stable during every wait.
